// File: rtl/delta_stream_sequencer.sv
// Stream-fed per-channel delta/index sequencer driving registered PE-array
// and output-buffer control, with channel mask, dense mode and start/done.
module delta_stream_sequencer #(
    parameter int CHANNELS      = 4,
    parameter int INDEX_WIDTH   = 8,
    parameter int DELTA_LEN     = 8,
    parameter int DELTA_SIM_LEN = 4,
    parameter int POS_W         = 10
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic                                    start_i,
    input  logic                                    mode_i,
    input  logic [CHANNELS-1:0]                     ch_mask_i,
    input  logic [CHANNELS-1:0]                     idx_valid_i,
    output logic [CHANNELS-1:0]                     idx_ready_o,
    input  logic [CHANNELS-1:0][INDEX_WIDTH-1:0]    idx_data_i,
    input  logic [CHANNELS-1:0]                     dl_valid_i,
    output logic [CHANNELS-1:0]                     dl_ready_o,
    input  logic [CHANNELS-1:0][DELTA_LEN-1:0]      dl_val_i,
    input  logic [CHANNELS-1:0][DELTA_SIM_LEN-1:0]  dl_sim_i,
    output logic [CHANNELS-1:0]                     mult_en_o,
    output logic [CHANNELS-1:0]                     shift_en_o,
    output logic [CHANNELS-1:0]                     w_en_o,
    output logic [CHANNELS-1:0][DELTA_LEN-1:0]      delta_out_o,
    output logic [CHANNELS-1:0][POS_W-1:0]          w_pos_o,
    output logic [CHANNELS-1:0]                     ch_done_o,
    output logic                                    done_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FIRST,
        S_RUN,
        S_DONE
    } state_e;

    state_e state_q [CHANNELS];
    state_e state_d [CHANNELS];

    logic [CHANNELS-1:0][POS_W-1:0]         pos_q, pos_d;
    logic [CHANNELS-1:0][DELTA_SIM_LEN-1:0] use_q, use_d;
    logic [CHANNELS-1:0][POS_W-1:0]         wpos_q, wpos_d;
    logic [CHANNELS-1:0][DELTA_LEN-1:0]     delta_q, delta_d;
    logic [CHANNELS-1:0]                    mult_q, mult_d;
    logic [CHANNELS-1:0]                    shift_q, shift_d;
    logic [CHANNELS-1:0]                    wen_q, wen_d;
    logic                                   mode_q, mode_d;
    logic                                   done_q, done_d;

    logic [CHANNELS-1:0] active;
    logic [CHANNELS-1:0] in_done;
    logic [CHANNELS-1:0] is_comp;
    logic [CHANNELS-1:0] is_end;
    logic [CHANNELS-1:0] use_dl;
    logic [CHANNELS-1:0] fire;
    logic                start_ok;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_dec
        assign active[g]  = (state_q[g] == S_FIRST) || (state_q[g] == S_RUN);
        assign in_done[g] = (state_q[g] == S_DONE);
        assign is_comp[g] = ~idx_data_i[g][INDEX_WIDTH-1];
        assign is_end[g]  = idx_data_i[g][INDEX_WIDTH-1] &&
                            (idx_data_i[g][INDEX_WIDTH-2:0] == '0);
        // Only RUN-state computes in delta mode wait on the delta stream
        assign use_dl[g]  = is_comp[g] && (state_q[g] == S_RUN) && !mode_q;
        assign fire[g]    = active[g] && idx_valid_i[g] &&
                            (!use_dl[g] || dl_valid_i[g]);
    end

    assign start_ok    = start_i && (active == '0);
    assign idx_ready_o = fire;

    always_comb begin
        mode_d     = start_ok ? mode_i : mode_q;
        done_d     = start_ok ? 1'b0 : (&in_done);
        dl_ready_o = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            state_d[c] = state_q[c];
            pos_d[c]   = pos_q[c];
            use_d[c]   = use_q[c];
            wpos_d[c]  = wpos_q[c];
            delta_d[c] = '0;
            mult_d[c]  = 1'b0;
            shift_d[c] = 1'b0;
            wen_d[c]   = 1'b0;
            if (start_ok) begin
                if (ch_mask_i[c]) begin
                    state_d[c] = S_FIRST;
                    pos_d[c]   = '0;
                    use_d[c]   = '0;
                end else begin
                    state_d[c] = S_DONE;
                end
            end else if (fire[c]) begin
                unique case (1'b1)
                    is_comp[c]: begin
                        state_d[c] = S_RUN;
                        wen_d[c]   = 1'b1;
                        wpos_d[c]  = pos_q[c];
                        pos_d[c]   = pos_q[c] + POS_W'(1);
                        if (use_dl[c]) begin
                            delta_d[c] = dl_val_i[c];
                            shift_d[c] = (use_q[c] == '0);
                            if (use_q[c] == dl_sim_i[c]) begin
                                dl_ready_o[c] = 1'b1;
                                use_d[c]      = '0;
                            end else begin
                                use_d[c] = use_q[c] + DELTA_SIM_LEN'(1);
                            end
                        end else begin
                            mult_d[c] = 1'b1;
                        end
                    end
                    is_end[c]: begin
                        // Drop a partly used delta token so the next tile is aligned
                        state_d[c]    = S_DONE;
                        dl_ready_o[c] = (use_q[c] != '0);
                        use_d[c]      = '0;
                    end
                    default: begin
                        pos_d[c] = pos_q[c] +
                                   POS_W'(idx_data_i[c][INDEX_WIDTH-2:0]);
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < CHANNELS; c++) begin
                state_q[c] <= S_IDLE;
            end
            pos_q   <= '0;
            use_q   <= '0;
            wpos_q  <= '0;
            delta_q <= '0;
            mult_q  <= '0;
            shift_q <= '0;
            wen_q   <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                state_q[c] <= state_d[c];
            end
            pos_q   <= pos_d;
            use_q   <= use_d;
            wpos_q  <= wpos_d;
            delta_q <= delta_d;
            mult_q  <= mult_d;
            shift_q <= shift_d;
            wen_q   <= wen_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    assign mult_en_o   = mult_q;
    assign shift_en_o  = shift_q;
    assign w_en_o      = wen_q;
    assign delta_out_o = delta_q;
    assign w_pos_o     = wpos_q;
    assign ch_done_o   = in_done;
    assign done_o      = done_q;

endmodule

// File: tb/tb_delta_stream_sequencer.sv
// Directed vector bench for delta_stream_sequencer: cycle tables plus
// hand sequences for reset, start-ignore and position wrap.
module tb_delta_stream_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start, mode;
    logic [3:0] mask, iv, ir, dv, dr, mult, shift, wen, chd;
    logic done;
    logic [3:0][7:0] idata, dval, dout;
    logic [3:0][3:0] dsim;
    logic [3:0][9:0] wpos;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    delta_stream_sequencer #(
        .CHANNELS(4), .INDEX_WIDTH(8), .DELTA_LEN(8),
        .DELTA_SIM_LEN(4), .POS_W(10)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mode_i(mode),
        .ch_mask_i(mask), .idx_valid_i(iv), .idx_ready_o(ir),
        .idx_data_i(idata), .dl_valid_i(dv), .dl_ready_o(dr),
        .dl_val_i(dval), .dl_sim_i(dsim), .mult_en_o(mult),
        .shift_en_o(shift), .w_en_o(wen), .delta_out_o(dout),
        .w_pos_o(wpos), .ch_done_o(chd), .done_o(done)
    );

    typedef struct {
        logic st; logic md; logic [3:0] mk;
        logic [3:0] iv; logic [7:0] id;
        logic [3:0] dv; logic [7:0] dl; logic [3:0] ds;
        logic [3:0] ir; logic [3:0] dr;
        logic [3:0] mu; logic [3:0] sh; logic [3:0] we;
        logic [7:0] dq; logic [9:0] wp; logic [3:0] cd; logic dn;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t v(logic st, logic md, logic [3:0] mk,
        logic [3:0] iv_, logic [7:0] id, logic [3:0] dv_, logic [7:0] dl,
        logic [3:0] ds, logic [3:0] ir_, logic [3:0] dr_, logic [3:0] mu,
        logic [3:0] sh, logic [3:0] we, logic [7:0] dq, logic [9:0] wp,
        logic [3:0] cd, logic dn);
        vec_t r;
        r.st = st; r.md = md; r.mk = mk; r.iv = iv_; r.id = id;
        r.dv = dv_; r.dl = dl; r.ds = ds; r.ir = ir_; r.dr = dr_;
        r.mu = mu; r.sh = sh; r.we = we; r.dq = dq; r.wp = wp;
        r.cd = cd; r.dn = dn;
        return r;
    endfunction

    task automatic drive(logic st, logic md, logic [3:0] mk, logic [3:0] iv_,
        logic [7:0] id, logic [3:0] dv_, logic [7:0] dl, logic [3:0] ds);
        start = st; mode = md; mask = mk; iv = iv_; dv = dv_;
        for (int c = 0; c < 4; c++) begin
            idata[c] = id; dval[c] = dl; dsim[c] = ds;
        end
    endtask

    task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s [%0d] got %0h want %0h", nm, k, act, exp);
        end
    endtask

    localparam logic [7:0] C = 8'h00;
    localparam logic [7:0] E = 8'h80;

    initial begin
        // st md mask iv id dv dl ds | ir dr | mu sh we dq wp cd dn
        // delta mode, one channel
        tv.push_back(v(1,0,4'h1,4'h0,C,4'h0,8'h00,0, 4'h0,4'h0, 4'h0,4'h0,4'h0,8'h00,0,4'he,0));
        tv.push_back(v(0,0,4'h1,4'h1,C,4'h1,8'h05,1, 4'h1,4'h0, 4'h1,4'h0,4'h1,8'h00,0,4'he,0));
        tv.push_back(v(0,0,4'h1,4'h1,C,4'h1,8'h05,1, 4'h1,4'h0, 4'h0,4'h1,4'h1,8'h05,1,4'he,0));
        tv.push_back(v(0,0,4'h1,4'h1,C,4'h1,8'h05,1, 4'h1,4'h1, 4'h0,4'h0,4'h1,8'h05,2,4'he,0));
        tv.push_back(v(0,0,4'h1,4'h1,C,4'h1,8'hfd,0, 4'h1,4'h1, 4'h0,4'h1,4'h1,8'hfd,3,4'he,0));
        tv.push_back(v(0,0,4'h1,4'h1,E,4'h0,8'h00,0, 4'h1,4'h0, 4'h0,4'h0,4'h0,8'h00,0,4'hf,0));
        tv.push_back(v(0,0,4'h1,4'h0,C,4'h0,8'h00,0, 4'h0,4'h0, 4'h0,4'h0,4'h0,8'h00,0,4'hf,1));
        // skip token P=3
        tv.push_back(v(1,0,4'h1,4'h0,C,4'h0,8'h00,0, 4'h0,4'h0, 4'h0,4'h0,4'h0,8'h00,0,4'he,0));
        tv.push_back(v(0,0,4'h1,4'h1,C,4'h0,8'h00,0, 4'h1,4'h0, 4'h1,4'h0,4'h1,8'h00,0,4'he,0));
        tv.push_back(v(0,0,4'h1,4'h1,8'h83,4'h0,8'h00,0, 4'h1,4'h0, 4'h0,4'h0,4'h0,8'h00,0,4'he,0));
        tv.push_back(v(0,0,4'h1,4'h1,C,4'h1,8'h07,0, 4'h1,4'h1, 4'h0,4'h1,4'h1,8'h07,4,4'he,0));
        tv.push_back(v(0,0,4'h1,4'h1,E,4'h0,8'h00,0, 4'h1,4'h0, 4'h0,4'h0,4'h0,8'h00,0,4'hf,0));
        tv.push_back(v(0,0,4'h1,4'h0,C,4'h0,8'h00,0, 4'h0,4'h0, 4'h0,4'h0,4'h0,8'h00,0,4'hf,1));
        // delta backpressure
        tv.push_back(v(1,0,4'h1,4'h0,C,4'h0,8'h00,0, 4'h0,4'h0, 4'h0,4'h0,4'h0,8'h00,0,4'he,0));
        tv.push_back(v(0,0,4'h1,4'h1,C,4'h0,8'h00,0, 4'h1,4'h0, 4'h1,4'h0,4'h1,8'h00,0,4'he,0));
        tv.push_back(v(0,0,4'h1,4'h1,C,4'h0,8'h00,0, 4'h0,4'h0, 4'h0,4'h0,4'h0,8'h00,0,4'he,0));
        tv.push_back(v(0,0,4'h1,4'h1,C,4'h0,8'h00,0, 4'h0,4'h0, 4'h0,4'h0,4'h0,8'h00,0,4'he,0));
        tv.push_back(v(0,0,4'h1,4'h1,C,4'h0,8'h00,0, 4'h0,4'h0, 4'h0,4'h0,4'h0,8'h00,0,4'he,0));
        tv.push_back(v(0,0,4'h1,4'h1,C,4'h1,8'h09,0, 4'h1,4'h1, 4'h0,4'h1,4'h1,8'h09,1,4'he,0));
        tv.push_back(v(0,0,4'h1,4'h1,E,4'h0,8'h00,0, 4'h1,4'h0, 4'h0,4'h0,4'h0,8'h00,0,4'hf,0));
        tv.push_back(v(0,0,4'h1,4'h0,C,4'h0,8'h00,0, 4'h0,4'h0, 4'h0,4'h0,4'h0,8'h00,0,4'hf,1));
        // dense mode, two channels
        tv.push_back(v(1,1,4'h3,4'h0,C,4'h0,8'h00,0, 4'h0,4'h0, 4'h0,4'h0,4'h0,8'h00,0,4'hc,0));
        tv.push_back(v(0,0,4'h3,4'h3,C,4'h3,8'h01,0, 4'h3,4'h0, 4'h3,4'h0,4'h3,8'h00,0,4'hc,0));
        tv.push_back(v(0,0,4'h3,4'h3,C,4'h3,8'h01,0, 4'h3,4'h0, 4'h3,4'h0,4'h3,8'h00,1,4'hc,0));
        tv.push_back(v(0,0,4'h3,4'h3,C,4'h3,8'h01,0, 4'h3,4'h0, 4'h3,4'h0,4'h3,8'h00,2,4'hc,0));
        tv.push_back(v(0,0,4'h3,4'h3,E,4'h3,8'h01,0, 4'h3,4'h0, 4'h0,4'h0,4'h0,8'h00,0,4'hf,0));
        tv.push_back(v(0,0,4'h3,4'h0,C,4'h0,8'h00,0, 4'h0,4'h0, 4'h0,4'h0,4'h0,8'h00,0,4'hf,1));
        // mask 0101, start during RUN ignored, partial delta discarded
        tv.push_back(v(1,0,4'h5,4'h0,C,4'h0,8'h00,0, 4'h0,4'h0, 4'h0,4'h0,4'h0,8'h00,0,4'ha,0));
        tv.push_back(v(0,0,4'h5,4'h5,C,4'h0,8'h00,0, 4'h5,4'h0, 4'h5,4'h0,4'h5,8'h00,0,4'ha,0));
        tv.push_back(v(1,0,4'hf,4'h5,C,4'h5,8'h02,3, 4'h5,4'h0, 4'h0,4'h5,4'h5,8'h02,1,4'ha,0));
        tv.push_back(v(0,0,4'h5,4'h1,E,4'h0,8'h00,0, 4'h1,4'h1, 4'h0,4'h0,4'h0,8'h00,0,4'hb,0));
        tv.push_back(v(0,0,4'h5,4'h4,E,4'h4,8'h02,3, 4'h4,4'h4, 4'h0,4'h0,4'h0,8'h00,0,4'hf,0));
        tv.push_back(v(0,0,4'h5,4'h0,C,4'h0,8'h00,0, 4'h0,4'h0, 4'h0,4'h0,4'h0,8'h00,0,4'hf,1));

        drive(0, 0, 4'h0, 4'hf, C, 4'hf, 8'h00, 0);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wen", 0, wen, 4'h0);
        chk("rst_mult", 0, mult, 4'h0);
        chk("rst_shift", 0, shift, 4'h0);
        chk("rst_delta", 0, dout, 32'h0);
        chk("rst_wpos", 0, wpos[0], 10'd0);
        chk("rst_ir", 0, ir, 4'h0);
        chk("rst_dr", 0, dr, 4'h0);
        chk("rst_chd", 0, chd, 4'h0);
        chk("rst_done", 0, done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 4'h0, 4'h0, C, 4'h0, 8'h00, 0);

        for (int k = 0; k < tv.size(); k++) begin
            @(negedge clk);
            drive(tv[k].st, tv[k].md, tv[k].mk, tv[k].iv, tv[k].id,
                  tv[k].dv, tv[k].dl, tv[k].ds);
            #1;
            chk("idx_ready", k, ir, tv[k].ir);
            chk("dl_ready", k, dr, tv[k].dr);
            @(posedge clk);
            #1;
            chk("mult_en", k, mult, tv[k].mu);
            chk("shift_en", k, shift, tv[k].sh);
            chk("w_en", k, wen, tv[k].we);
            chk("delta_out", k, dout[0], tv[k].dq);
            chk("ch_done", k, chd, tv[k].cd);
            chk("done", k, done, tv[k].dn);
            if (tv[k].we[0]) chk("w_pos0", k, wpos[0], tv[k].wp);
            if (tv[k].we[1]) chk("w_pos1", k, wpos[1], tv[k].wp);
        end

        // reset asserted mid-tile
        @(negedge clk);
        drive(1, 0, 4'h1, 4'h0, C, 4'h0, 8'h00, 0);
        @(negedge clk);
        drive(0, 0, 4'h1, 4'h1, C, 4'h1, 8'h11, 0);
        @(posedge clk);
        #1;
        chk("mid_pre_wen", 0, wen, 4'h1);
        @(posedge clk);
        #1;
        chk("mid_pre_delta", 0, dout[0], 8'h11);
        chk("mid_pre_chd", 0, chd, 4'he);
        rst_n = 1'b0;
        #1;
        chk("mid_wen", 0, wen, 4'h0);
        chk("mid_delta", 0, dout[0], 8'h00);
        chk("mid_wpos", 0, wpos[0], 10'd0);
        chk("mid_ir", 0, ir, 4'h0);
        chk("mid_chd", 0, chd, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 4'h1, 4'h0, C, 4'h0, 8'h00, 0);

        // position wrap: 8*127 + 7 = 1023
        @(negedge clk);
        drive(1, 0, 4'h1, 4'h0, C, 4'h0, 8'h00, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(0, 0, 4'h1, 4'h1, 8'hff, 4'h0, 8'h00, 0);
        end
        @(negedge clk);
        drive(0, 0, 4'h1, 4'h1, 8'h87, 4'h0, 8'h00, 0);
        @(negedge clk);
        drive(0, 0, 4'h1, 4'h1, C, 4'h0, 8'h00, 0);
        @(posedge clk);
        #1;
        chk("wrap_wen_a", 0, wen, 4'h1);
        chk("wrap_pos_a", 0, wpos[0], 10'd1023);
        @(negedge clk);
        drive(0, 0, 4'h1, 4'h1, C, 4'h1, 8'h01, 0);
        @(posedge clk);
        #1;
        chk("wrap_wen_b", 0, wen, 4'h1);
        chk("wrap_shift_b", 0, shift, 4'h1);
        chk("wrap_pos_b", 0, wpos[0], 10'd0);
        @(negedge clk);
        drive(0, 0, 4'h1, 4'h1, E, 4'h0, 8'h00, 0);
        @(negedge clk);
        drive(0, 0, 4'h1, 4'h0, C, 4'h0, 8'h00, 0);
        @(posedge clk);
        #1;
        chk("wrap_chd", 0, chd, 4'hf);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/delta_stream_sequencer.md
# delta_stream_sequencer

Parametrised, stream-fed successor to the per-channel delta/index control of the delta processing unit. It consumes per-channel index-token and delta-token streams over valid/ready handshakes and drives registered PE-array control: multiply, delta-shift, delta value, output-buffer write enable and output position. It adds a channel mask, a dense (multiply-only) mode and a restartable start/done protocol for back-to-back tiles. It sits between the token fetch buffers and the processing-element array / output buffer.

## Interface
- CHANNELS, 4, number of independent input channels
- INDEX_WIDTH, 8, index token width; MSB = skip flag, low INDEX_WIDTH-1 bits = payload P
- DELTA_LEN, 8, delta value width
- DELTA_SIM_LEN, 4, delta reuse-count width
- POS_W, 10, output position counter width
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; low clears all state immediately
- start  in  1  one-cycle pulse; begins a tile; honoured only when every channel is IDLE or DONE
- mode  in  1  sampled on start: 0 = delta mode, 1 = dense mode
- ch_mask  in  CHANNELS  sampled on start; 0 = channel skipped (goes directly to DONE)
- idx_valid / idx_ready  in / out  CHANNELS  index stream handshake per channel
- idx_data  in  CHANNELS x INDEX_WIDTH  index token
- dl_valid / dl_ready  in / out  CHANNELS  delta stream handshake per channel
- dl_val  in  CHANNELS x DELTA_LEN  delta value
- dl_sim  in  CHANNELS x DELTA_SIM_LEN  delta token used for dl_sim+1 compute tokens
- mult_en, shift_en, w_en  out  CHANNELS  registered PE / output-buffer strobes
- delta_out  out  CHANNELS x DELTA_LEN  registered delta applied this cycle
- w_pos  out  CHANNELS x POS_W  registered output position for w_en
- ch_done  out  CHANNELS  channel finished current tile
- done  out  1  all channels finished

## Operation
- Per-channel FSM: IDLE -> (start) FIRST or DONE if masked; FIRST -> RUN on first compute token accepted; FIRST/RUN -> DONE on end token; DONE -> FIRST on start. Start in FIRST/RUN on any channel: ignored globally.
- Token decode: MSB=0 compute; MSB=1, P>0 skip; MSB=1, P=0 end.
- Compute token, FIRST or dense mode: fires when idx_valid; mult_en=1, w_en=1, no delta consumed.
- Compute token, RUN, delta mode: fires when idx_valid && dl_valid; w_en=1, delta_out=dl_val; shift_en=1 only on first use of the current delta token. Use counter increments per fire; when counter == dl_sim, dl_ready=1 same cycle (pop concurrent with last use), counter clears.
- Skip token: fires when idx_valid; pos += P (mod 2^POS_W); no strobes; no delta consumed.
- End token: fires when idx_valid; channel -> DONE. A partially used delta token is discarded (dl_ready pulses once) so the next tile starts aligned.
- Compute fire: strobes emitted with w_pos = pos, then pos += 1 (mod 2^POS_W).
- idx_ready = fire condition; combinational from state and valids. No fire -> bubble (all strobes 0 next cycle).
- start clears pos and delta use counter of unmasked channels.

## Timing
- Reset values: all strobes 0, delta_out 0, w_pos 0, idx_ready 0, dl_ready 0, ch_done 0, done 0, all FSMs IDLE.
- Token accepted at edge t -> strobes, delta_out, w_pos valid in cycle t+1, one cycle wide.
- ch_done rises the cycle after end token accepted (or after start if masked); falls the cycle after start.
- done = registered AND of ch_done: rises one cycle after last ch_done; falls the cycle after start.
- Throughput: one token per channel per cycle with valid held high.
- Reset asserted mid-tile: outputs clear asynchronously; upstream streams must be flushed externally.
- Position wrap: 2^POS_W-1 + 1 -> 0, no flag.

## Test plan
- Delta mode, one channel, tokens compute x4, end; delta (5, sim=1),(−3, sim=0) -> w_pos 0,1,2,3; mult_en at pos0; delta_out 5,5,−3 at pos1-3; shift_en at pos1 and pos3; dl_ready pulses twice; done 2 cycles after end.
- Skip: compute, skip P=3, compute, end -> w_en at w_pos 0 and 4, no strobe for skip cycle.
- Backpressure: dl_valid low 3 cycles before second compute -> idx_ready low, 3 bubble cycles, no w_en, then resumes with correct delta.
- Dense mode, 2 channels, 3 computes each -> mult_en on all 6 writes, dl_ready never asserted.
- ch_mask=4'b0101, start -> ch_done[1],[3] next cycle; done only after channels 0 and 2 end; start while ch0 in RUN ignored.
- Reset low mid-tile -> all outputs 0 immediately; POS_W wrap test: skip P to pos 1023, compute twice -> w_pos 1023 then 0.
